// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM encoding, requester IDs, abort data.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_CONF = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; on contention the side that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the CPU port and the host config port (round-robin).
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner; pick a requester and latch its command
// BUSY    | strobe held on memory, waiting for mem_ready
// RESP    | one-cycle ready pulse with captured read data to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_valid,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wstrb,
  output logic                  cpu_ready,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  conf_valid,
  input  logic                  conf_we,
  input  logic [ADDR_W-1:0]     conf_addr,
  input  logic [DATA_W-1:0]     conf_wdata,
  output logic                  conf_ready,
  output logic [DATA_W-1:0]     conf_rdata,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic                  owner_conf,
  output logic                  timeout_err
);

  localparam int STRB_W = DATA_W / 8;

  logic [1:0] state_q;
  logic       last_q;
  logic       owner_q;
  logic       gnt_valid;
  logic       gnt_id;
  logic       busy_done;
  logic [DATA_W-1:0] resp_data;

  rr_pick2 u_pick (
    .req       ({conf_valid, cpu_valid}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_expired;
  logic            timeout_err_q;

  assign timeout_err = timeout_err_q;

  always_comb begin
    to_expired = !mem_ready && (to_cnt == '0);
    busy_done  = mem_ready || to_expired;
    resp_data  = mem_wren ? '0 : mem_rdata;
    if (to_expired) resp_data = DATA_W'(TIMEOUT_RDATA);
  end

  // Watchdog down-counter: loaded on grant, terminal count on the TIMEOUT-th BUSY cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      to_cnt <= TO_W'(TIMEOUT - 1);
    end else if (state_q == ST_BUSY) begin
      if (to_expired) timeout_err_q <= 1'b1;
      else if (!mem_ready) to_cnt <= to_cnt - 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_err    = 1'b0;

  always_comb begin
    busy_done = mem_ready;
    resp_data = mem_wren ? '0 : mem_rdata;
  end
`endif

  assign owner_conf = (state_q != ST_IDLE) && (owner_q == REQ_CONF);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      last_q     <= REQ_CONF;
      owner_q    <= REQ_CPU;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      conf_ready <= 1'b0;
      conf_rdata <= '0;
      mem_rden   <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_id;
            last_q  <= gnt_id;
            state_q <= ST_BUSY;
            if (gnt_id == REQ_CONF) begin
              mem_addr  <= conf_addr;
              mem_wdata <= conf_wdata;
              mem_wstrb <= conf_we ? {STRB_W{1'b1}} : '0;
              mem_wren  <= conf_we;
              mem_rden  <= !conf_we;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_wstrb <= cpu_wstrb;
              mem_wren  <= |cpu_wstrb;
              mem_rden  <= ~|cpu_wstrb;
            end
          end
        end
        ST_BUSY: begin
          if (busy_done) begin
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            state_q  <= ST_RESP;
            if (owner_q == REQ_CONF) begin
              conf_ready <= 1'b1;
              conf_rdata <= resp_data;
            end else begin
              cpu_ready <= 1'b1;
              cpu_rdata <= resp_data;
            end
          end
        end
        ST_RESP: begin
          cpu_ready  <= 1'b0;
          cpu_rdata  <= '0;
          conf_ready <= 1'b0;
          conf_rdata <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench plays the SRAM by driving mem_ready/mem_rdata.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        conf_valid;
  logic        conf_we;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic        conf_ready;
  logic [31:0] conf_rdata;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        owner_conf;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .cpu_valid   (cpu_valid),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_ready   (cpu_ready),
    .cpu_rdata   (cpu_rdata),
    .conf_valid  (conf_valid),
    .conf_we     (conf_we),
    .conf_addr   (conf_addr),
    .conf_wdata  (conf_wdata),
    .conf_ready  (conf_ready),
    .conf_rdata  (conf_rdata),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .owner_conf  (owner_conf),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    conf_valid = 1'b0; conf_we = 1'b0; conf_addr = '0; conf_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_mem_rden", 32'(mem_rden), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: lone CPU read of 0x100
    cpu_valid = 1'b1; cpu_addr = 32'h100; cpu_wstrb = 4'h0;
    tick();
    chk("t1_rden", 32'(mem_rden), 32'd1);
    chk("t1_wren", 32'(mem_wren), 32'd0);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_owner", 32'(owner_conf), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("t1_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("t1_cpu_rdata", cpu_rdata, 32'h1234_5678);
    chk("t1_conf_ready", 32'(conf_ready), 32'd0);
    chk("t1_rden_drop", 32'(mem_rden), 32'd0);
    mem_ready = 1'b0; cpu_valid = 1'b0;
    tick();
    chk("t1_ready_pulse", 32'(cpu_ready), 32'd0);
    chk("t1_rdata_clear", cpu_rdata, 32'd0);
    tick();
    chk("t1_no_regrant", 32'(mem_rden), 32'd0);

    // 2: simultaneous requests after reset alternate CPU, CONF, CPU, CONF
    do_reset();
    cpu_valid = 1'b1; cpu_addr = 32'h10; cpu_wstrb = 4'h0;
    conf_valid = 1'b1; conf_we = 1'b0; conf_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_owner_%0d", i), 32'(owner_conf), 32'(i % 2));
      mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      chk($sformatf("t2_cpu_ready_%0d", i), 32'(cpu_ready), 32'((i + 1) % 2));
      chk($sformatf("t2_conf_ready_%0d", i), 32'(conf_ready), 32'(i % 2));
      mem_ready = 1'b0;
      tick();
    end
    cpu_valid = 1'b0; conf_valid = 1'b0;
    tick();

    // 3: host full-word write
    conf_valid = 1'b1; conf_we = 1'b1; conf_addr = 32'h40; conf_wdata = 32'hA5A5_A5A5;
    tick();
    chk("t3_wren", 32'(mem_wren), 32'd1);
    chk("t3_rden", 32'(mem_rden), 32'd0);
    chk("t3_wstrb", 32'(mem_wstrb), 32'hF);
    chk("t3_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("t3_addr", mem_addr, 32'h40);
    chk("t3_owner", 32'(owner_conf), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("t3_conf_ready", 32'(conf_ready), 32'd1);
    chk("t3_conf_rdata", conf_rdata, 32'd0);
    chk("t3_cpu_ready", 32'(cpu_ready), 32'd0);
    mem_ready = 1'b0; conf_valid = 1'b0; conf_we = 1'b0;
    tick();

    // 4: CPU halfword store, host read arrives mid-BUSY and waits
    cpu_valid = 1'b1; cpu_addr = 32'h204; cpu_wdata = 32'h1122_3344; cpu_wstrb = 4'b0011;
    tick();
    chk("t4_wren", 32'(mem_wren), 32'd1);
    chk("t4_wstrb", 32'(mem_wstrb), 32'h3);
    conf_valid = 1'b1; conf_addr = 32'h80;
    tick();
    chk("t4_hold_addr", mem_addr, 32'h204);
    chk("t4_hold_owner", 32'(owner_conf), 32'd0);
    chk("t4_hold_rden", 32'(mem_rden), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    chk("t4_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("t4_cpu_rdata", cpu_rdata, 32'd0);
    chk("t4_strobes_off", 32'({mem_rden, mem_wren}), 32'd0);
    mem_ready = 1'b0; cpu_valid = 1'b0;
    tick();
    chk("t4_idle_strobes", 32'({mem_rden, mem_wren}), 32'd0);
    tick();
    chk("t4_conf_rden", 32'(mem_rden), 32'd1);
    chk("t4_conf_addr", mem_addr, 32'h80);
    chk("t4_conf_owner", 32'(owner_conf), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    chk("t4_conf_ready", 32'(conf_ready), 32'd1);
    chk("t4_conf_rdata", conf_rdata, 32'hCAFE_0001);
    mem_ready = 1'b0; conf_valid = 1'b0;
    tick();

    // 5: asynchronous reset during BUSY
    cpu_valid = 1'b1; cpu_addr = 32'h300; cpu_wstrb = 4'h0;
    tick();
    chk("t5_busy_rden", 32'(mem_rden), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_rden", 32'(mem_rden), 32'd0);
    chk("t5_async_owner", 32'(owner_conf), 32'd0);
    chk("t5_async_addr", mem_addr, 32'd0);
    cpu_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    chk("t5_no_stale_ready", 32'(cpu_ready), 32'd0);
    chk("t5_no_restrobe", 32'(mem_rden), 32'd0);
    mem_ready = 1'b0;
    tick();
    chk("t5_still_quiet", 32'(cpu_ready), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: memory never answers; watchdog aborts after 64 BUSY cycles
    begin
      int n;
      n = 0;
      cpu_valid = 1'b1; cpu_addr = 32'h400; cpu_wstrb = 4'h0;
      tick();
      while (!cpu_ready && n < 100) begin
        tick();
        n++;
      end
      chk("t6_latency", 32'(n), 32'd64);
      chk("t6_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("t6_err", 32'(timeout_err), 32'd1);
      cpu_valid = 1'b0;
      tick();
      tick();
      chk("t6_err_sticky", 32'(timeout_err), 32'd1);
      chk("t6_rdata_clear", cpu_rdata, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
